// File: rtl/ula_muldiv_seq.sv
// ula_muldiv_seq: sequential unsigned multiply / divide, one bit per cycle.
//   Multiply: shift-add into a 2*WIDTH-bit accumulator.
//   Divide:   restoring division, MSB first.
// Optional build macro:
//   ULA_MULDIV_EARLY_EXIT_EN - a multiply finishes as soon as no multiplier
//                              bits remain (at least one iteration).
//                              Divide timing and all results are unchanged.
module ula_muldiv_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             mult_overflow,
  output logic             div_error
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic                 op_q;
  logic [2*WIDTH-1:0]   mcand_q;   // multiplicand, shifted left each iteration
  logic [WIDTH-1:0]     mplier_q;  // multiplier, shifted right each iteration
  logic [2*WIDTH-1:0]   acc_q;     // product accumulator
  logic [WIDTH-1:0]     b_q;       // divisor
  logic [WIDTH-1:0]     rem_q;     // partial remainder
  logic [WIDTH-1:0]     quo_q;     // dividend shifting out / quotient shifting in

  logic [WIDTH-1:0]     result_q, remainder_q;
  logic                 ovf_q, derr_q;

  logic                 accept, div0, last_iter;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]     mp_nxt;
  logic [WIDTH:0]       r_sh, trial;
  logic                 borrow;
  logic [WIDTH-1:0]     rem_nxt, quo_nxt;

  // A new operation is only taken when nothing is in flight.
  assign accept = start && (state_q != S_BUSY);
  assign div0   = op_div && (B == '0);

  // One iteration of each datapath, evaluated every cycle.
  always_comb begin
    acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
    mp_nxt  = mplier_q >> 1;
    r_sh    = {rem_q, quo_q[WIDTH-1]};
    trial   = r_sh - {1'b0, b_q};
    borrow  = (r_sh < {1'b0, b_q});
    rem_nxt = borrow ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nxt = (quo_q << 1) | {{(WIDTH-1){1'b0}}, ~borrow};
    if (op_q) begin
      last_iter = (cnt_q == CW'(WIDTH-1));
    end else begin
`ifdef ULA_MULDIV_EARLY_EXIT_EN
      last_iter = (mp_nxt == '0);
`else
      last_iter = (cnt_q == CW'(WIDTH-1));
`endif
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: launch from IDLE/DONE, iterate in BUSY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start)                 state_d = div0 ? S_DONE : S_BUSY;
        else                       state_d = S_IDLE;
      end
      S_BUSY: if (last_iter)       state_d = S_DONE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // FSM outputs: status flags straight from the state.
  always_comb begin
    busy = (state_q == S_BUSY);
    done = (state_q == S_DONE);
  end

  // Datapath: operand latch, iteration and result capture on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      op_q        <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
      derr_q      <= 1'b0;
    end else if (accept) begin
      cnt_q    <= '0;
      op_q     <= op_div;
      mcand_q  <= {{WIDTH{1'b0}}, A};
      mplier_q <= B;
      acc_q    <= '0;
      b_q      <= B;
      rem_q    <= '0;
      quo_q    <= A;
      if (div0) begin
        result_q    <= '1;
        remainder_q <= A;
        ovf_q       <= 1'b0;
        derr_q      <= 1'b1;
      end
    end else if (state_q == S_BUSY) begin
      cnt_q    <= cnt_q + 1'b1;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mp_nxt;
      acc_q    <= acc_nxt;
      rem_q    <= rem_nxt;
      quo_q    <= quo_nxt;
      if (last_iter) begin
        derr_q <= 1'b0;
        if (op_q) begin
          result_q    <= quo_nxt;
          remainder_q <= rem_nxt;
          ovf_q       <= 1'b0;
        end else begin
          result_q    <= acc_nxt[WIDTH-1:0];
          remainder_q <= '0;
          ovf_q       <= |acc_nxt[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

  assign result        = result_q;
  assign remainder     = remainder_q;
  assign mult_overflow = ovf_q;
  assign div_error     = derr_q;

endmodule
